// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM-stage access unit of the pipelined MIPS core. It reads the
//               EX/MEM register outputs and issues data-memory requests over a
//               req/ready handshake. While a load or store is outstanding it
//               stalls EX/MEM and all earlier stages. If memory does not answer
//               within WAIT_LIMIT wait cycles, the request is aborted. The unit
//               writes the MEM/WB register.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               RegWriteM..write_regM       - EX/MEM register outputs
//               mem_req/we/addr/wdata       - request to data memory
//               mem_ready/rdata             - response from data memory
//               stallM                      - hold EX/MEM and earlier stages
//               RegWriteW..write_regW       - MEM/WB register
//               addr_errW                   - pulse: misaligned access dropped
//               mem_timeout                 - pulse: request aborted
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] alu_resultM,
    input  logic [DATA_WIDTH-1:0] write_dataM,
    input  logic [4:0]            write_regM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stallM,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [DATA_WIDTH-1:0] read_dataW,
    output logic [DATA_WIDTH-1:0] alu_resultW,
    output logic [4:0]            write_regW,
    output logic                  addr_errW,
    output logic                  mem_timeout
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, cnt_next;

    logic is_mem, access, misaligned, is_load;
    logic abort, complete, pass_thru, misaligned_drop;

    assign is_mem     = MemtoRegM | MemWriteM;
    assign access     = is_mem & (alu_resultM[1:0] == 2'b00);
    assign misaligned = is_mem & (alu_resultM[1:0] != 2'b00);
    // Load+store together is illegal; it is handled as a plain store.
    assign is_load    = MemtoRegM & ~MemWriteM;

    assign mem_req   = rst_n & (((state == IDLE) & access) | (state == WAIT));
    assign mem_we    = MemWriteM;
    assign mem_addr  = {alu_resultM[DATA_WIDTH-1:2], 2'b00};
    assign mem_wdata = write_dataM;

    // Abort on the last allowed wait cycle; stall is released in that same
    // cycle so the aborted instruction leaves M and is not re-issued.
    assign abort    = (state == WAIT) & ~mem_ready & (wait_cnt == CNT_LAST);
    assign complete = mem_req & mem_ready;
    assign stallM   = mem_req & ~mem_ready & ~abort;

    assign pass_thru       = (state == IDLE) & ~is_mem;
    assign misaligned_drop = (state == IDLE) & misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = wait_cnt;
        case (state)
            IDLE: begin
                if (access && !mem_ready) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (mem_ready || abort) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // MEM/WB register. Stall, abort and misaligned cycles insert a bubble;
    // data fields are left untouched on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            read_dataW  <= '0;
            alu_resultW <= '0;
            write_regW  <= '0;
            addr_errW   <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            addr_errW   <= misaligned_drop;
            mem_timeout <= abort;
            if (complete || pass_thru) begin
                RegWriteW   <= RegWriteM;
                MemtoRegW   <= is_load;
                alu_resultW <= alu_resultM;
                write_regW  <= write_regM;
                if (complete && is_load) begin
                    read_dataW <= mem_rdata;
                end
            end else begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage (WAIT_LIMIT = 4).
//               A request-age model predicts every output each cycle, and
//               directed scenarios add hand-computed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int DW = 32;
    localparam int WL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RegWriteM, MemtoRegM, MemWriteM;
    logic [DW-1:0] alu_resultM, write_dataM;
    logic [4:0]    write_regM;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          stallM;
    logic          RegWriteW, MemtoRegW;
    logic [DW-1:0] read_dataW, alu_resultW;
    logic [4:0]    write_regW;
    logic          addr_errW, mem_timeout;

    int vectors    = 0;
    int miscompares = 0;

    mem_access_stage #(.DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .alu_resultM(alu_resultM), .write_dataM(write_dataM), .write_regM(write_regM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stallM(stallM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .read_dataW(read_dataW), .alu_resultW(alu_resultW), .write_regW(write_regW),
        .addr_errW(addr_errW), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a memory instruction in M keeps requesting until
    // ready; "age" counts cycles it has already spent unanswered. Age
    // WAIT_LIMIT without ready means the request window is exhausted.
    // ------------------------------------------------------------------
    logic          exp_rw, exp_mr, exp_aerr, exp_to;
    logic [DW-1:0] exp_rd, exp_alu;
    logic [4:0]    exp_wr;
    int            age;

    always @(negedge clk) begin
        logic is_mem, acc, mis, ld, done, abrt;
        if (!rst_n) begin
            check("rst_RegWriteW", RegWriteW, 0);
            check("rst_MemtoRegW", MemtoRegW, 0);
            check("rst_read_dataW", read_dataW, 0);
            check("rst_alu_resultW", alu_resultW, 0);
            check("rst_write_regW", write_regW, 0);
            check("rst_addr_errW", addr_errW, 0);
            check("rst_mem_timeout", mem_timeout, 0);
            check("rst_mem_req", mem_req, 0);
            {exp_rw, exp_mr, exp_aerr, exp_to} = '0;
            exp_rd = '0; exp_alu = '0; exp_wr = '0; age = 0;
        end else begin
            is_mem = MemtoRegM | MemWriteM;
            acc    = is_mem && (alu_resultM % 4 == 0);
            mis    = is_mem && !acc;
            ld     = MemtoRegM && !MemWriteM;
            done   = acc && mem_ready;
            abrt   = acc && !mem_ready && (age == WL);

            check("RegWriteW", RegWriteW, exp_rw);
            check("MemtoRegW", MemtoRegW, exp_mr);
            check("read_dataW", read_dataW, exp_rd);
            check("alu_resultW", alu_resultW, exp_alu);
            check("write_regW", write_regW, exp_wr);
            check("addr_errW", addr_errW, exp_aerr);
            check("mem_timeout", mem_timeout, exp_to);
            check("mem_req", mem_req, acc);
            check("mem_we", mem_we, MemWriteM);
            check("mem_addr", mem_addr, alu_resultM - (alu_resultM % 4));
            check("mem_wdata", mem_wdata, write_dataM);
            check("stallM", stallM, acc && !mem_ready && !abrt);

            exp_aerr = 1'b0;
            exp_to   = 1'b0;
            if (done || !is_mem) begin
                exp_rw  = RegWriteM;
                exp_mr  = ld;
                exp_alu = alu_resultM;
                exp_wr  = write_regM;
                if (done && ld) exp_rd = mem_rdata;
                age = 0;
            end else begin
                exp_rw = 1'b0;
                exp_mr = 1'b0;
                if (mis) begin
                    exp_aerr = 1'b1;
                    age = 0;
                end else if (abrt) begin
                    exp_to = 1'b1;
                    age = 0;
                end else begin
                    age++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after each rising edge.
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic rw, input logic ld, input logic st,
                         input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [4:0] wr);
        RegWriteM = rw; MemtoRegM = ld; MemWriteM = st;
        alu_resultM = addr; write_dataM = wd; write_regM = wr;
    endtask

    initial begin
        int stalls, reqs, pulses;
        logic stall4, stall5;
        rst_n = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        cycle(); cycle();
        check("hand_rst_mem_req", mem_req, 0);
        check("hand_rst_RegWriteW", RegWriteW, 0);
        rst_n = 1'b1;
        cycle();

        // ALU pass-through; ready while no request must be ignored
        set_m(1, 0, 0, 32'h1234, 32'h0, 5);
        mem_ready = 1'b1;
        #2;
        check("hand_alu_mem_req", mem_req, 0);
        check("hand_alu_stall", stallM, 0);
        cycle();
        check("hand_alu_RegWriteW", RegWriteW, 1);
        check("hand_alu_resultW", alu_resultW, 32'h1234);
        check("hand_alu_write_regW", write_regW, 5);

        // zero-wait load
        set_m(1, 1, 0, 32'h40, 32'h0, 7);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #2;
        check("hand_ld_stall", stallM, 0);
        cycle();
        check("hand_ld_read_dataW", read_dataW, 32'hDEADBEEF);
        check("hand_ld_MemtoRegW", MemtoRegW, 1);

        // store with 3 wait cycles
        set_m(0, 0, 1, 32'h80, 32'hCAFEF00D, 0);
        mem_ready = 1'b0; mem_rdata = 32'h11111111;
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            if (stallM) stalls++;
            cycle();
            check("hand_st_bubble", RegWriteW, 0);
        end
        mem_ready = 1'b1;
        #2;
        if (stallM) stalls++;
        cycle();
        check("hand_st_stall_cycles", stalls, 3);
        check("hand_st_read_data_held", read_dataW, 32'hDEADBEEF);
        check("hand_st_alu_resultW", alu_resultW, 32'h80);

        // load with no answer: timeout after WL+1 request cycles
        set_m(1, 1, 0, 32'h100, 32'h0, 9);
        mem_ready = 1'b0;
        reqs = 0; pulses = 0; stall4 = 1'b0; stall5 = 1'b1;
        for (int i = 0; i < WL + 1; i++) begin
            #2;
            if (mem_req) reqs++;
            if (i == WL - 1) stall4 = stallM;
            if (i == WL) stall5 = stallM;
            cycle();
            if (mem_timeout) pulses++;
        end
        check("hand_to_req_cycles", reqs, WL + 1);
        check("hand_to_stall_before_last", stall4, 1);
        check("hand_to_stall_last", stall5, 0);
        check("hand_to_bubble", RegWriteW, 0);
        set_m(1, 0, 0, 32'h55, 32'h0, 4);
        cycle();
        if (mem_timeout) pulses++;
        check("hand_to_pulses", pulses, 1);

        // misaligned load
        set_m(1, 1, 0, 32'h42, 32'h0, 3);
        #2;
        check("hand_mis_mem_req", mem_req, 0);
        cycle();
        check("hand_mis_addr_errW", addr_errW, 1);
        check("hand_mis_RegWriteW", RegWriteW, 0);
        set_m(0, 0, 0, 32'h0, 32'h0, 0);
        cycle();
        check("hand_mis_pulse_end", addr_errW, 0);

        // illegal load+store: behaves as a store
        set_m(1, 1, 1, 32'h200, 32'h77, 6);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        cycle();
        check("hand_ill_MemtoRegW", MemtoRegW, 0);
        check("hand_ill_read_data_held", read_dataW, 32'hDEADBEEF);

        // load with 1 wait then store with 2 waits, back to back
        set_m(1, 1, 0, 32'h304, 32'h0, 12);
        mem_ready = 1'b0; mem_rdata = 32'h12345678;
        cycle();
        mem_ready = 1'b1;
        cycle();
        check("hand_ld1_read_dataW", read_dataW, 32'h12345678);
        set_m(0, 0, 1, 32'h30B, 32'h99, 0);
        mem_ready = 1'b0;
        cycle();
        set_m(0, 0, 1, 32'h308, 32'h99, 0);
        cycle(); cycle();
        mem_ready = 1'b1;
        cycle();

        // reset while waiting
        set_m(1, 1, 0, 32'h300, 32'h0, 8);
        mem_ready = 1'b0;
        cycle(); cycle();
        #2;
        check("hand_wait_mem_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("hand_async_mem_req_drop", mem_req, 0);
        cycle();
        rst_n = 1'b1;
        set_m(1, 0, 0, 32'hABC, 32'h0, 2);
        #2;
        check("hand_post_rst_mem_req", mem_req, 0);
        cycle();
        check("hand_post_rst_alu_resultW", alu_resultW, 32'hABC);
        check("hand_post_rst_RegWriteW", RegWriteW, 1);
        set_m(0, 0, 0, 32'h0, 32'h0, 0);
        cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage access unit for the pipelined MIPS core. It consumes the EX/MEM register outputs and drives a data-memory request/ready handshake. It stalls the front of the pipeline while a load or store is outstanding. On completion it registers the MEM/WB pipeline values, making it the reader side of the EX/MEM interface and the writer of the MEM/WB interface.

## Interface
- DATA_WIDTH, 32, data/address width
- WAIT_LIMIT, 15, max WAIT-state cycles before a request is aborted (≥1)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWriteM  in  1  register-write enable of M-stage instruction
- MemtoRegM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- alu_resultM  in  DATA_WIDTH  ALU result / effective address
- write_dataM  in  DATA_WIDTH  store data
- write_regM  in  5  destination register
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  DATA_WIDTH  word address {alu_resultM[DATA_WIDTH-1:2],2'b00}
- mem_wdata  out  DATA_WIDTH  equals write_dataM
- mem_ready  in  1  memory accepts/completes request this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1
- stallM  out  1  hold EX/MEM and all earlier stages
- RegWriteW, MemtoRegW  out  1 each  WB control
- read_dataW, alu_resultW  out  DATA_WIDTH each  WB data
- write_regW  out  5  WB destination
- addr_errW  out  1  one-cycle pulse: misaligned access dropped
- mem_timeout  out  1  one-cycle pulse: request aborted

## Operation
- access = (MemtoRegM | MemWriteM) & (alu_resultM[1:0]==0). misaligned = (MemtoRegM | MemWriteM) & (alu_resultM[1:0]!=0).
- Both MemtoRegM and MemWriteM set is illegal. It is treated as a store, and MemtoRegW is captured as 0.
- FSM states IDLE, WAIT. Reset state IDLE.
- mem_req = rst_n & ((IDLE & access) | WAIT). mem_we = MemWriteM. mem_addr and mem_wdata are combinational from M inputs, held stable by stallM.
- IDLE:
  - access & mem_ready: zero-wait completion, stay IDLE.
  - access & !mem_ready: go to WAIT, clear wait_cnt.
  - Otherwise (non-memory op or misaligned): single-cycle pass-through.
- WAIT:
  - mem_ready: completion, go to IDLE.
  - Otherwise, if wait_cnt == WAIT_LIMIT-1: abort, go to IDLE, pulse mem_timeout.
  - Otherwise: wait_cnt+1.
- stallM = mem_req & !mem_ready & !abort. It is low on the abort cycle so the aborted instruction leaves and is not re-issued.
- WB register update, every edge:
  - Completion or pass-through: capture M values. read_dataW = mem_rdata on a load completion, else holds its previous value.
  - Stall or abort cycle: load a bubble (RegWriteW=0, MemtoRegW=0). Data fields are don't-care and hold.
  - Misaligned: bubble plus addr_errW=1 for one cycle.
- A store completion captures RegWriteW=RegWriteM, normally 0.

## Timing
- Reset (async, rst_n low): state IDLE, wait_cnt 0. All registered outputs are 0: RegWriteW, MemtoRegW, read_dataW, alu_resultW, write_regW, addr_errW, mem_timeout. mem_req is forced 0 while rst_n is low.
- Reset mid-WAIT drops the request immediately with no bubble pulse. The memory must tolerate a withdrawn mem_req.
- Latency: non-memory op M→W is 1 edge. A load or store with N wait cycles (mem_ready first high on request cycle N, 0-based) holds stallM for N cycles. W values appear at edge N+1.
- Maximum mem_req duration is WAIT_LIMIT+1 cycles, including the issue cycle. mem_timeout rises at the edge ending that window.
- Handshake: a request completes on the single cycle with mem_req & mem_ready. mem_ready while mem_req=0 is ignored.
- wait_cnt width is clog2(WAIT_LIMIT+1). It never wraps.

## Test plan
- Reset, then release: all W outputs 0, mem_req 0. Assert rst_n low during WAIT: mem_req falls without a clock edge, and state is IDLE after release.
- ALU op RegWriteM=1, alu_resultM=0x1234, write_regM=5: next edge RegWriteW=1, alu_resultW=0x1234, write_regW=5. mem_req stays 0 and stallM stays 0.
- Zero-wait load, addr 0x40, mem_ready=1, mem_rdata=0xDEADBEEF: stallM 0. Next edge read_dataW=0xDEADBEEF, MemtoRegW=1.
- Store to 0x80, data 0xCAFEF00D, mem_ready low for 3 cycles: stallM high for exactly 3 cycles, mem_we=1, mem_addr/mem_wdata stable. RegWriteW=0 on the bubbles, then completion.
- WAIT_LIMIT=4, mem_ready never asserted: mem_req high for 5 cycles, stallM low on the 5th. mem_timeout pulses once, then IDLE with a bubble in WB.
- Load with alu_resultM=0x42: mem_req 0, addr_errW pulses 1 cycle, RegWriteW=0.
